// File: rtl/cc_fifo_pkg.sv
// Shared pointer helpers for the clock-converter async FIFO (read and write sides).
// Functions work on a fixed maximum width; callers zero-extend and truncate at the call site.
package cc_fifo_pkg;

  localparam int PTR_W_DEFAULT = 4;
  localparam int PTR_W_MAX     = 16;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input ptr_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PTR_W_MAX; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cc_gray_ptr_reg.sv
// Binary FIFO pointer with a registered Gray copy; shared by the read and write sides.
// The Gray output comes straight from a flop so the far-side synchronizer sees one-bit steps.
module cc_gray_ptr_reg
  import cc_fifo_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [PTR_W-1:0] bin_o,
  output logic [PTR_W-1:0] bin_nxt_o,
  output logic [PTR_W-1:0] gray_o
);

  logic [PTR_W-1:0] bin_q;
  logic [PTR_W-1:0] bin_d;
  logic [PTR_W-1:0] gray_q;
  logic [PTR_W-1:0] gray_d;

  always_comb begin
    bin_d  = bin_q + PTR_W'(inc_i);
    gray_d = PTR_W'(bin2gray(ptr_t'(bin_d)));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin_o     = bin_q;
  assign bin_nxt_o = bin_d;
  assign gray_o    = gray_q;

endmodule

// File: rtl/cc_rd_ptr_gray_tx.sv
// Read-domain pointer block of the async FIFO: owns the read pointer, publishes it in Gray,
// and turns the synchronized Gray write pointer into empty/occupancy/error status.
module cc_rd_ptr_gray_tx
  import cc_fifo_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEFAULT
) (
  input  logic             s_aclk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] wr_ptr_gray_sync,
  output logic [PTR_W-1:0] rd_ptr_gray,
  output logic [PTR_W-2:0] rd_addr,
  output logic             rd_fire,
  output logic             empty,
  output logic [PTR_W-1:0] occupancy,
  output logic             underflow,
  output logic             gray_err
);

  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(2 ** (PTR_W - 1));

  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] rd_bin_nxt;
  logic [PTR_W-1:0] wr_gray_q;
  logic             empty_q;
  logic             empty_d;
  logic [PTR_W-1:0] occ_q;
  logic [PTR_W-1:0] occ_d;
  logic [PTR_W-1:0] occ_calc;
  logic             occ_ovf;
  logic             gray_jump;
  logic             underflow_q;
  logic             gray_err_q;
  logic             gray_err_d;

  assign rd_fire = rd_en & ~empty_q;

  cc_gray_ptr_reg #(
    .PTR_W(PTR_W)
  ) u_rd_ptr (
    .clk      (s_aclk),
    .rst      (rst),
    .inc_i    (rd_fire),
    .bin_o    (rd_bin),
    .bin_nxt_o(rd_bin_nxt),
    .gray_o   (rd_ptr_gray)
  );

  // Status is computed against the post-read pointer so a same-cycle write and read net out.
  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    occ_calc   = PTR_W'(gray2bin(ptr_t'(wr_ptr_gray_sync))) - rd_bin_nxt;
    occ_ovf    = occ_calc > DEPTH;
    gray_jump  = popcount(ptr_t'(wr_gray_q ^ wr_ptr_gray_sync)) > 1;
    empty_d    = PTR_W'(bin2gray(ptr_t'(rd_bin_nxt))) == wr_ptr_gray_sync;
    occ_d      = occ_ovf ? occ_q : occ_calc;
    gray_err_d = gray_err_q | gray_jump | occ_ovf;
  end

  always_ff @(posedge s_aclk or posedge rst) begin
    if (rst) begin
      wr_gray_q   <= '0;
      empty_q     <= 1'b1;
      occ_q       <= '0;
      underflow_q <= 1'b0;
      gray_err_q  <= 1'b0;
    end else begin
      wr_gray_q   <= wr_ptr_gray_sync;
      empty_q     <= empty_d;
      occ_q       <= occ_d;
      underflow_q <= rd_en & empty_q;
      gray_err_q  <= gray_err_d;
    end
  end

  assign rd_addr   = rd_bin[PTR_W-2:0];
  assign empty     = empty_q;
  assign occupancy = occ_q;
  assign underflow = underflow_q;
  assign gray_err  = gray_err_q;

endmodule

// File: tb/tb_cc_rd_ptr_gray_tx.sv
// Directed bench for cc_rd_ptr_gray_tx: a vector table for fill/drain/underflow/full,
// plus hand-written sequences for wrap, reset mid-stream and protocol errors.
module tb_cc_rd_ptr_gray_tx;

  logic       s_aclk;
  logic       rst;
  logic       rd_en;
  logic [3:0] wr_ptr_gray_sync;
  logic [3:0] rd_ptr_gray;
  logic [2:0] rd_addr;
  logic       rd_fire;
  logic       empty;
  logic [3:0] occupancy;
  logic       underflow;
  logic       gray_err;

  int checks = 0;
  int errors = 0;

  cc_rd_ptr_gray_tx #(.PTR_W(4)) dut (
    .s_aclk          (s_aclk),
    .rst             (rst),
    .rd_en           (rd_en),
    .wr_ptr_gray_sync(wr_ptr_gray_sync),
    .rd_ptr_gray     (rd_ptr_gray),
    .rd_addr         (rd_addr),
    .rd_fire         (rd_fire),
    .empty           (empty),
    .occupancy       (occupancy),
    .underflow       (underflow),
    .gray_err        (gray_err)
  );

  initial s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  typedef struct {
    logic       rd_en;
    logic [3:0] wr;
    logic       fire;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       empty;
    logic [3:0] occ;
    logic       uf;
    logic       err;
  } vec_t;

  vec_t vecs[17];
  logic [3:0] gray_tab[16];

  function automatic vec_t mk(input logic en, input logic [3:0] wr, input logic f,
                              input logic [2:0] a, input logic [3:0] g, input logic e,
                              input logic [3:0] o, input logic u, input logic x);
    vec_t v;
    v.rd_en = en; v.wr = wr; v.fire = f; v.addr = a; v.gray = g;
    v.empty = e; v.occ = o; v.uf = u; v.err = x;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] g, input logic e,
                             input logic [3:0] o, input logic u, input logic x);
    check({tag, ".rd_ptr_gray"}, 32'(rd_ptr_gray), 32'(g));
    check({tag, ".empty"},       32'(empty),       32'(e));
    check({tag, ".occupancy"},   32'(occupancy),   32'(o));
    check({tag, ".underflow"},   32'(underflow),   32'(u));
    check({tag, ".gray_err"},    32'(gray_err),    32'(x));
  endtask

  // Drive at the falling edge, check combinational outputs, then registered ones after the rise.
  task automatic step(input logic en, input logic [3:0] wr, input string tag,
                      input logic f, input logic [2:0] a);
    @(negedge s_aclk);
    rd_en = en;
    wr_ptr_gray_sync = wr;
    #1;
    check({tag, ".rd_fire"}, 32'(rd_fire), 32'(f));
    check({tag, ".rd_addr"}, 32'(rd_addr), 32'(a));
    @(posedge s_aclk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge s_aclk);
    rst = 1'b1;
    rd_en = 1'b0;
    wr_ptr_gray_sync = 4'd0;
    @(negedge s_aclk);
    rst = 1'b0;
  endtask

  initial begin
    int rb;
    int wb;
    logic [3:0] prev_gray;

    gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    //            en  wr    fire addr gray  emp occ   uf err
    vecs[0]  = mk(0, 4'h1, 0, 3'd0, 4'h0, 0, 4'd1, 0, 0);
    vecs[1]  = mk(0, 4'h3, 0, 3'd0, 4'h0, 0, 4'd2, 0, 0);
    vecs[2]  = mk(0, 4'h2, 0, 3'd0, 4'h0, 0, 4'd3, 0, 0);
    vecs[3]  = mk(1, 4'h2, 1, 3'd0, 4'h1, 0, 4'd2, 0, 0);
    vecs[4]  = mk(1, 4'h2, 1, 3'd1, 4'h3, 0, 4'd1, 0, 0);
    vecs[5]  = mk(1, 4'h2, 1, 3'd2, 4'h2, 1, 4'd0, 0, 0);
    vecs[6]  = mk(1, 4'h2, 0, 3'd3, 4'h2, 1, 4'd0, 1, 0);
    vecs[7]  = mk(0, 4'h2, 0, 3'd3, 4'h2, 1, 4'd0, 0, 0);
    vecs[8]  = mk(0, 4'h6, 0, 3'd3, 4'h2, 0, 4'd1, 0, 0);
    vecs[9]  = mk(1, 4'h7, 1, 3'd3, 4'h6, 0, 4'd1, 0, 0);
    vecs[10] = mk(0, 4'h5, 0, 3'd4, 4'h6, 0, 4'd2, 0, 0);
    vecs[11] = mk(0, 4'h4, 0, 3'd4, 4'h6, 0, 4'd3, 0, 0);
    vecs[12] = mk(0, 4'hC, 0, 3'd4, 4'h6, 0, 4'd4, 0, 0);
    vecs[13] = mk(0, 4'hD, 0, 3'd4, 4'h6, 0, 4'd5, 0, 0);
    vecs[14] = mk(0, 4'hF, 0, 3'd4, 4'h6, 0, 4'd6, 0, 0);
    vecs[15] = mk(0, 4'hE, 0, 3'd4, 4'h6, 0, 4'd7, 0, 0);
    vecs[16] = mk(0, 4'hA, 0, 3'd4, 4'h6, 0, 4'd8, 0, 0);

    // Power-on reset
    rst = 1'b1;
    rd_en = 1'b0;
    wr_ptr_gray_sync = 4'd0;
    #1;
    check_state("por", 4'h0, 1'b1, 4'd0, 1'b0, 1'b0);
    check("por.rd_addr", 32'(rd_addr), 32'd0);
    @(negedge s_aclk);
    @(negedge s_aclk);
    rst = 1'b0;

    // Fill, drain, underflow, simultaneous write+read, fill to full
    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].rd_en, vecs[i].wr, tag, vecs[i].fire, vecs[i].addr);
      check_state(tag, vecs[i].gray, vecs[i].empty, vecs[i].occ, vecs[i].uf, vecs[i].err);
    end

    // Wrap: 20 reads while the write pointer advances in lockstep; occupancy stays at 8
    rb = 4;
    wb = 12;
    for (int i = 0; i < 20; i++) begin
      prev_gray = rd_ptr_gray;
      wb = (wb + 1) % 16;
      step(1'b1, gray_tab[wb], $sformatf("wrap%0d", i), 1'b1, 3'(rb % 8));
      rb = (rb + 1) % 16;
      check_state($sformatf("wrap%0d", i), gray_tab[rb], 1'b0, 4'd8, 1'b0, 1'b0);
      check($sformatf("wrap%0d.one_bit", i), 32'($countones(prev_gray ^ rd_ptr_gray)), 32'd1);
    end

    // Drain from full to empty with the write pointer held
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, gray_tab[wb], $sformatf("drain%0d", k), 1'b1, 3'(rb % 8));
      rb = (rb + 1) % 16;
      check_state($sformatf("drain%0d", k), gray_tab[rb], (k == 8), 4'(8 - k), 1'b0, 1'b0);
    end

    // Build up rd_bin=5 with one entry left, then reset mid-stream
    for (int k = 1; k <= 6; k++) begin
      wb = k;
      step(1'b0, gray_tab[wb], $sformatf("refill%0d", k), 1'b0, 3'd0);
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, gray_tab[wb], $sformatf("reread%0d", k), 1'b1, 3'(k));
    end
    check_state("pre_rst", 4'h7, 1'b0, 4'd1, 1'b0, 1'b0);
    @(negedge s_aclk);
    rd_en = 1'b1;
    rst = 1'b1;
    #1;
    check_state("rst_async", 4'h0, 1'b1, 4'd0, 1'b0, 1'b0);
    check("rst_async.rd_addr", 32'(rd_addr), 32'd0);
    check("rst_async.rd_fire", 32'(rd_fire), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge s_aclk);
      #1;
      check_state($sformatf("rst_hold%0d", k), 4'h0, 1'b1, 4'd0, 1'b0, 1'b0);
    end
    @(negedge s_aclk);
    rd_en = 1'b0;
    wr_ptr_gray_sync = 4'd0;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 4'h0, $sformatf("post_rst%0d", k), 1'b0, 3'd0);
      check_state($sformatf("post_rst%0d", k), 4'h0, 1'b1, 4'd0, 1'b0, 1'b0);
    end

    // Protocol error: two Gray bits change at once; sticky until reset
    step(1'b0, 4'h3, "jump", 1'b0, 3'd0);
    check_state("jump", 4'h0, 1'b0, 4'd2, 1'b0, 1'b1);
    step(1'b0, 4'h2, "jump_hold0", 1'b0, 3'd0);
    check_state("jump_hold0", 4'h0, 1'b0, 4'd3, 1'b0, 1'b1);
    step(1'b1, 4'h2, "jump_hold1", 1'b1, 3'd0);
    check_state("jump_hold1", 4'h1, 1'b0, 4'd2, 1'b0, 1'b1);
    pulse_reset();
    #1;
    check_state("err_clr", 4'h0, 1'b1, 4'd0, 1'b0, 1'b0);

    // Occupancy above depth: legal Gray steps to 9 ahead flag an error and hold occupancy at 8
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, gray_tab[k], $sformatf("ovf%0d", k), 1'b0, 3'd0);
      check_state($sformatf("ovf%0d", k), 4'h0, 1'b0, 4'((k > 8) ? 8 : k), 1'b0, (k == 9));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
